// File: rtl/fdiv_share_arb.sv
// Round-robin arbiter sharing one FP divider between two cores: grant, start, wait, respond.
// Optional hung-divider watchdog enabled by defining FDIV_ARB_TIMEOUT_EN.
module fdiv_share_arb #(
   parameter int TIMEOUT_CYC = 40
) (
   input  logic        in_Clk,
   input  logic        in_Rst_N,
   input  logic        in_c0_req,
   input  logic        in_c1_req,
   input  logic [31:0] in_c0_a,
   input  logic [31:0] in_c0_b,
   input  logic [31:0] in_c1_a,
   input  logic [31:0] in_c1_b,
   input  logic        in_c0_flush,
   input  logic        in_c1_flush,
   output logic        out_c0_gnt,
   output logic        out_c1_gnt,
   output logic        out_c0_busy,
   output logic        out_c1_busy,
   output logic        out_c0_done,
   output logic        out_c1_done,
   output logic [31:0] out_result,
   output logic        out_err,
   output logic        out_div_start,
   output logic [31:0] out_div_a,
   output logic [31:0] out_div_b,
   input  logic        in_div_done,
   input  logic [31:0] in_div_result
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

   state_t      state;
   logic        owner, rr_ptr, killed;
   logic [1:0]  gnt, busy, done;
   logic [1:0]  flush_v, req_ok;
   logic        pick, own_flush;
   logic [1:0]  own_onehot;

   assign flush_v    = {in_c1_flush, in_c0_flush};
   assign req_ok     = {in_c1_req, in_c0_req} & ~flush_v;
   assign pick       = (&req_ok) ? rr_ptr : req_ok[1];
   assign own_flush  = flush_v[owner];
   assign own_onehot = owner ? 2'b10 : 2'b01;

   assign out_c0_gnt  = gnt[0];
   assign out_c1_gnt  = gnt[1];
   assign out_c0_busy = busy[0];
   assign out_c1_busy = busy[1];
   assign out_c0_done = done[0];
   assign out_c1_done = done[1];

   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
   end

`ifdef FDIV_ARB_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT_CYC + 1);
   logic [WDW-1:0] wd_cnt;
   logic           err_q;
   assign out_err = err_q;
`else
   assign out_err = 1'b0;
`endif

   always_ff @(posedge in_Clk) begin
      if (!in_Rst_N) begin
         state         <= S_IDLE;
         owner         <= 1'b0;
         rr_ptr        <= 1'b0;
         killed        <= 1'b0;
         gnt           <= '0;
         busy          <= '0;
         done          <= '0;
         out_result    <= '0;
         out_div_start <= 1'b0;
         out_div_a     <= '0;
         out_div_b     <= '0;
`ifdef FDIV_ARB_TIMEOUT_EN
         wd_cnt        <= '0;
         err_q         <= 1'b0;
`endif
      end else begin
         gnt           <= '0;
         done          <= '0;
         out_div_start <= 1'b0;
`ifdef FDIV_ARB_TIMEOUT_EN
         err_q         <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (|req_ok) begin
                  owner         <= pick;
                  rr_ptr        <= ~pick;
                  killed        <= 1'b0;
                  gnt           <= pick ? 2'b10 : 2'b01;
                  busy          <= pick ? 2'b10 : 2'b01;
                  out_div_start <= 1'b1;
                  out_div_a     <= pick ? in_c1_a : in_c0_a;
                  out_div_b     <= pick ? in_c1_b : in_c0_b;
                  state         <= S_WAIT;
`ifdef FDIV_ARB_TIMEOUT_EN
                  wd_cnt        <= '0;
`endif
               end
            end
            S_WAIT: begin
               // The divider cannot be aborted; a flushed op still runs to completion silently.
               if (own_flush) killed <= 1'b1;
               if (in_div_done) begin
                  out_result <= in_div_result;
                  done       <= (killed || own_flush) ? 2'b00 : own_onehot;
                  state      <= S_RESP;
               end
`ifdef FDIV_ARB_TIMEOUT_EN
               else if (wd_cnt == WDW'(TIMEOUT_CYC - 1)) begin
                  out_result <= CANON_NAN;
                  err_q      <= 1'b1;
                  done       <= (killed || own_flush) ? 2'b00 : own_onehot;
                  state      <= S_RESP;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
`endif
            end
            S_RESP: begin
               busy  <= '0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifndef FDIV_ARB_TIMEOUT_EN
   logic unused_nan;
   assign unused_nan = ^CANON_NAN;
`endif

endmodule

// File: tb/tb_fdiv_share_arb.sv
// Bench for fdiv_share_arb: vector table, directed latency/contention sequences, random vs model.
// Watchdog sequence is included when FDIV_ARB_TIMEOUT_EN is defined.
module tb_fdiv_share_arb;

   localparam logic [31:0] A0 = 32'h3F80_0000, B0 = 32'h4000_0000;
   localparam logic [31:0] A1 = 32'h4040_0000, B1 = 32'h3F80_0000;

   logic        in_Clk = 1'b0;
   logic        in_Rst_N;
   logic        c0_req, c1_req, c0_fl, c1_fl;
   logic [31:0] c0_a, c0_b, c1_a, c1_b;
   logic        c0_gnt, c1_gnt, c0_busy, c1_busy, c0_done, c1_done;
   logic [31:0] result, div_a, div_b, div_res;
   logic        err, div_start, div_done;

   int total = 0;
   int bad   = 0;

   always #5 in_Clk = ~in_Clk;

   fdiv_share_arb dut (
      .in_Clk(in_Clk), .in_Rst_N(in_Rst_N),
      .in_c0_req(c0_req), .in_c1_req(c1_req),
      .in_c0_a(c0_a), .in_c0_b(c0_b), .in_c1_a(c1_a), .in_c1_b(c1_b),
      .in_c0_flush(c0_fl), .in_c1_flush(c1_fl),
      .out_c0_gnt(c0_gnt), .out_c1_gnt(c1_gnt),
      .out_c0_busy(c0_busy), .out_c1_busy(c1_busy),
      .out_c0_done(c0_done), .out_c1_done(c1_done),
      .out_result(result), .out_err(err),
      .out_div_start(div_start), .out_div_a(div_a), .out_div_b(div_b),
      .in_div_done(div_done), .in_div_result(div_res)
   );

   typedef struct {
      logic       rst;
      logic [1:0] req, fl;
      logic       dd;
      logic [31:0] dres;
      logic [1:0] gnt, busy, done;
      logic       start;
      logic [31:0] res;
      int         op;
   } vec_t;

   vec_t tbl[18];

   // reference model state
   int          m_owner;
   bit          m_resp, m_rr, m_killed;
   logic [1:0]  e_gnt, e_busy, e_done;
   logic        e_start, e_err;
   logic [31:0] e_result, e_a, e_b;

   function automatic logic [103:0] act();
      return {c1_gnt, c0_gnt, c1_busy, c0_busy, c1_done, c0_done, div_start, err, result, div_a, div_b};
   endfunction

   function automatic logic [103:0] exp_pack();
      return {e_gnt, e_busy, e_done, e_start, e_err, e_result, e_a, e_b};
   endfunction

   task automatic chk(input string nm, input logic [103:0] got, input logic [103:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge in_Clk);
      #1;
   endtask

   task automatic drive(input logic rst, input logic [1:0] req, input logic [1:0] fl,
                        input logic dd, input logic [31:0] dres);
      in_Rst_N = rst;
      {c1_req, c0_req} = req;
      {c1_fl, c0_fl}   = fl;
      div_done = dd;
      div_res  = dres;
   endtask

   // One clock of arbiter behaviour expressed as transaction rules.
   task automatic model_step(input logic rst, input logic [1:0] req, input logic [1:0] fl,
                             input logic [31:0] a0, input logic [31:0] b0,
                             input logic [31:0] a1, input logic [31:0] b1,
                             input logic dd, input logic [31:0] dres);
      logic [1:0] cand;
      int w;
      e_gnt = 2'b00; e_done = 2'b00; e_start = 1'b0; e_err = 1'b0;
      if (!rst) begin
         m_owner = -1; m_resp = 0; m_rr = 0; m_killed = 0;
         e_busy = 2'b00; e_result = '0; e_a = '0; e_b = '0;
      end else if (m_resp) begin
         m_resp = 0; m_owner = -1; e_busy = 2'b00;
      end else if (m_owner < 0) begin
         cand = req & ~fl;
         if (cand != 2'b00) begin
            w = (cand == 2'b11) ? int'(m_rr) : (cand[1] ? 1 : 0);
            m_owner = w; m_rr = (w == 0); m_killed = 0;
            e_gnt[w] = 1'b1; e_busy = 2'b00; e_busy[w] = 1'b1; e_start = 1'b1;
            e_a = (w == 1) ? a1 : a0;
            e_b = (w == 1) ? b1 : b0;
         end
      end else begin
         if (fl[m_owner]) m_killed = 1;
         if (dd) begin
            e_result = dres;
            e_done[m_owner] = !m_killed;
            m_resp = 1;
         end
      end
   endtask

   initial begin
      logic [103:0] ex;
      logic         ok;
      int           n, dcnt;
      logic         r_rst, r_dd;
      logic [1:0]   r_req, r_fl;
      logic [31:0]  r_dres;

      c0_a = A0; c0_b = B0; c1_a = A1; c1_b = B1;
      drive(1'b0, 2'b00, 2'b00, 1'b0, '0);

      //          rst  req    fl     dd   dres            gnt    busy   done   st   res           op
      tbl[0]  = '{1'b0, 2'b00, 2'b00, 1'b0, 32'h0,        2'b00, 2'b00, 2'b00, 1'b0, 32'h0,        0};
      tbl[1]  = '{1'b1, 2'b00, 2'b00, 1'b1, 32'h12345678, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0,        0};
      tbl[2]  = '{1'b1, 2'b01, 2'b00, 1'b0, 32'h0,        2'b01, 2'b01, 2'b00, 1'b1, 32'h0,        1};
      tbl[3]  = '{1'b1, 2'b01, 2'b00, 1'b0, 32'h0,        2'b00, 2'b01, 2'b00, 1'b0, 32'h0,        1};
      tbl[4]  = '{1'b1, 2'b01, 2'b00, 1'b1, 32'h3F000000, 2'b00, 2'b01, 2'b01, 1'b0, 32'h3F000000, 1};
      tbl[5]  = '{1'b1, 2'b00, 2'b00, 1'b0, 32'h0,        2'b00, 2'b00, 2'b00, 1'b0, 32'h3F000000, 1};
      tbl[6]  = '{1'b1, 2'b11, 2'b00, 1'b0, 32'h0,        2'b10, 2'b10, 2'b00, 1'b1, 32'h3F000000, 2};
      tbl[7]  = '{1'b1, 2'b11, 2'b10, 1'b0, 32'h0,        2'b00, 2'b10, 2'b00, 1'b0, 32'h3F000000, 2};
      tbl[8]  = '{1'b1, 2'b11, 2'b00, 1'b1, 32'hAAAA5555, 2'b00, 2'b10, 2'b00, 1'b0, 32'hAAAA5555, 2};
      tbl[9]  = '{1'b1, 2'b01, 2'b00, 1'b0, 32'h0,        2'b00, 2'b00, 2'b00, 1'b0, 32'hAAAA5555, 2};
      tbl[10] = '{1'b1, 2'b11, 2'b00, 1'b0, 32'h0,        2'b01, 2'b01, 2'b00, 1'b1, 32'hAAAA5555, 1};
      tbl[11] = '{1'b1, 2'b01, 2'b01, 1'b1, 32'h0F0F0F0F, 2'b00, 2'b01, 2'b00, 1'b0, 32'h0F0F0F0F, 1};
      tbl[12] = '{1'b1, 2'b00, 2'b00, 1'b0, 32'h0,        2'b00, 2'b00, 2'b00, 1'b0, 32'h0F0F0F0F, 1};
      tbl[13] = '{1'b1, 2'b11, 2'b01, 1'b0, 32'h0,        2'b10, 2'b10, 2'b00, 1'b1, 32'h0F0F0F0F, 2};
      tbl[14] = '{1'b0, 2'b10, 2'b00, 1'b0, 32'h0,        2'b00, 2'b00, 2'b00, 1'b0, 32'h0,        0};
      tbl[15] = '{1'b1, 2'b00, 2'b00, 1'b1, 32'h55AA55AA, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0,        0};
      tbl[16] = '{1'b1, 2'b11, 2'b00, 1'b0, 32'h0,        2'b01, 2'b01, 2'b00, 1'b1, 32'h0,        1};
      tbl[17] = '{1'b1, 2'b01, 2'b10, 1'b0, 32'h0,        2'b00, 2'b01, 2'b00, 1'b0, 32'h0,        1};

      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].rst, tbl[i].req, tbl[i].fl, tbl[i].dd, tbl[i].dres);
         tick();
         ex = {tbl[i].gnt, tbl[i].busy, tbl[i].done, tbl[i].start, 1'b0, tbl[i].res,
               (tbl[i].op == 1) ? A0 : (tbl[i].op == 2) ? A1 : 32'h0,
               (tbl[i].op == 1) ? B0 : (tbl[i].op == 2) ? B1 : 32'h0};
         chk($sformatf("vec%0d", i), act(), ex);
      end

      // Contention after reset: core0 first with a 25-cycle divider, core1 two cycles after done0.
      drive(1'b0, 2'b00, 2'b00, 1'b0, '0); tick();
      drive(1'b1, 2'b11, 2'b00, 1'b0, '0); tick();
      chk("seq_gnt0", act(), {2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 32'h0, A0, B0});
      ok = 1'b1;
      for (int k = 0; k < 24; k++) begin
         tick();
         if (!(c0_busy && !c0_done && !c1_busy && !c1_gnt && !div_start)) ok = 1'b0;
      end
      chk("seq_hold", {103'h0, ok}, {103'h0, 1'b1});
      drive(1'b1, 2'b11, 2'b00, 1'b1, 32'h3F000000); tick();
      chk("seq_done0", act(), {2'b00, 2'b01, 2'b01, 1'b0, 1'b0, 32'h3F000000, A0, B0});
      drive(1'b1, 2'b10, 2'b00, 1'b0, '0); tick();
      chk("seq_gap", act(), {2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h3F000000, A0, B0});
      tick();
      chk("seq_gnt1", act(), {2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 32'h3F000000, A1, B1});
      drive(1'b1, 2'b00, 2'b00, 1'b0, '0); tick();
      drive(1'b1, 2'b00, 2'b00, 1'b1, 32'h3EAAAAAB); tick();
      chk("seq_done1", act(), {2'b00, 2'b10, 2'b10, 1'b0, 1'b0, 32'h3EAAAAAB, A1, B1});
      drive(1'b1, 2'b00, 2'b00, 1'b0, '0); tick();
      drive(1'b1, 2'b11, 2'b00, 1'b0, '0); tick();
      chk("seq_rr_back0", act(), {2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 32'h3EAAAAAB, A0, B0});

`ifdef FDIV_ARB_TIMEOUT_EN
      drive(1'b0, 2'b00, 2'b00, 1'b0, '0); tick();
      drive(1'b1, 2'b01, 2'b00, 1'b0, '0); tick();
      chk("wd_gnt", act(), {2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 32'h0, A0, B0});
      n = 0;
      for (int k = 1; k <= 60 && n == 0; k++) begin
         tick();
         if (c0_done) n = k;
      end
      chk("wd_cycles", 104'(n), 104'd40);
      chk("wd_resp", {100'h0, err, c0_done, c0_busy, c1_done}, {100'h0, 4'b1110});
      chk("wd_nan", 104'(result), 104'h7FC00000);
      drive(1'b1, 2'b00, 2'b00, 1'b0, '0); tick();
`endif

      // Random stimulus against the model; the divider answers with random latency.
      dcnt = -1;
      for (int c = 0; c < 3000; c++) begin
         r_rst = (c == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
         r_req = {($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6)};
         r_fl  = {($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0)};
         c0_a = $urandom; c0_b = $urandom; c1_a = $urandom; c1_b = $urandom;
         if (dcnt == 0) begin
            r_dd = 1'b1; r_dres = e_a ^ {e_b[15:0], e_b[31:16]}; dcnt = -1;
         end else begin
            r_dd = (dcnt < 0) && ($urandom_range(0, 19) == 0);
            r_dres = $urandom;
            if (dcnt > 0) dcnt--;
         end
         drive(r_rst, r_req, r_fl, r_dd, r_dres);
         tick();
         model_step(r_rst, r_req, r_fl, c0_a, c0_b, c1_a, c1_b, r_dd, r_dres);
         chk($sformatf("rand%0d", c), act(), exp_pack());
         if (!r_rst) dcnt = -1;
         else if (e_start) dcnt = $urandom_range(0, 10);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
